// File: rtl/div_bcd_conv.sv
`default_nettype none
// ============================================================================
// Module      : div_bcd_conv
// Description : Sequential binary-to-BCD converter for the divider's quotient
//               and remainder. Both values are converted in parallel with
//               shift-and-add-3 (double dabble), one bit per clock, and
//               presented through a valid/ready handshake.
// Ports       : clk       - system clock, rising edge
//               rst       - synchronous active-low reset
//               in_valid  - upstream operands valid
//               in_ready  - converter idle, can accept operands
//               quo, rem  - unsigned binary operands (WIDTH bits)
//               out_valid - q_bcd/r_bcd hold a completed conversion
//               out_ready - downstream accepts the result
//               q_bcd     - packed BCD of quo, digit 0 in bits [3:0]
//               r_bcd     - packed BCD of rem, same packing
//               busy      - conversion in progress or result pending
// Revision    : 1.0 - initial release
// ============================================================================
module div_bcd_conv #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      quo,
    input  logic [WIDTH-1:0]      rem,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   q_bcd,
    output logic [4*DIGITS-1:0]   r_bcd,
    output logic                  busy
);

    localparam int c_bcd_w = 4 * DIGITS;
    localparam int c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [WIDTH-1:0]     r_q_bin;
    logic [WIDTH-1:0]     r_r_bin;
    logic [c_bcd_w-1:0]   r_q_acc;
    logic [c_bcd_w-1:0]   r_r_acc;
    logic [c_bcd_w-1:0]   r_q_bcd;
    logic [c_bcd_w-1:0]   r_r_bcd;
    logic [c_bcd_w-1:0]   w_q_adj;
    logic [c_bcd_w-1:0]   w_r_adj;
    logic [c_bcd_w-1:0]   w_q_shift;
    logic [c_bcd_w-1:0]   w_r_shift;

    // All nibbles are corrected in the same cycle, before the shift, so a
    // nibble of 5..9 becomes 8..12 and its carry moves up on the shift.
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        assign w_q_adj[4*i +: 4] = (r_q_acc[4*i +: 4] >= 4'd5) ?
                                   r_q_acc[4*i +: 4] + 4'd3 : r_q_acc[4*i +: 4];
        assign w_r_adj[4*i +: 4] = (r_r_acc[4*i +: 4] >= 4'd5) ?
                                   r_r_acc[4*i +: 4] + 4'd3 : r_r_acc[4*i +: 4];
    end

    // The MSB of the binary register enters the BCD accumulator's LSB.
    assign w_q_shift = {w_q_adj[c_bcd_w-2:0], r_q_bin[WIDTH-1]};
    assign w_r_shift = {w_r_adj[c_bcd_w-2:0], r_r_bin[WIDTH-1]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)        w_state_nxt = S_SHIFT;
            S_SHIFT: if (r_cnt == c_last) w_state_nxt = S_DONE;
            S_DONE:  if (out_ready)       w_state_nxt = S_IDLE;
            default:                      w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_q_bin <= '0;
            r_r_bin <= '0;
            r_q_acc <= '0;
            r_r_acc <= '0;
            r_q_bcd <= '0;
            r_r_bcd <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_q_bin <= quo;
                        r_r_bin <= rem;
                        r_q_acc <= '0;
                        r_r_acc <= '0;
                        r_cnt   <= '0;
                    end
                end
                S_SHIFT: begin
                    r_q_acc <= w_q_shift;
                    r_r_acc <= w_r_shift;
                    r_q_bin <= {r_q_bin[WIDTH-2:0], 1'b0};
                    r_r_bin <= {r_r_bin[WIDTH-2:0], 1'b0};
                    r_cnt   <= r_cnt + 1'b1;
                    // Outputs only change when a full conversion completes,
                    // so they stay stable through DONE and after handshake.
                    if (r_cnt == c_last) begin
                        r_q_bcd <= w_q_shift;
                        r_r_bcd <= w_r_shift;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign q_bcd     = r_q_bcd;
    assign r_bcd     = r_r_bcd;

endmodule
`default_nettype wire
